tx_flit_arbiter: RTL
====================

// Module: tx_flit_arbiter
// PURPOSE
//  Sequenced arbiter sharing the single inter-device TX port between three flit sources: ACK queue,
//  waiting-ack (retransmit) queue and forwarded queue. Sits between those flit_queue pops and
//  interdevice_controller TX. Fixed priority with starvation guard, packet lock for multi-flit
//  forwarded packets, and one registered output stage.
// PARAMETERS
//  STARVE_LIMIT  16  cycles a valid, ungranted RETX/FWD source waits before forced priority (>=1)
//  CNT_W         $clog2(STARVE_LIMIT+1)  derived width of starvation counters; not overridden
// PORTS
//  nocclk          in   1       NoC clock; single clock domain
//  rst             in   1       synchronous, active-high reset
//  ack_flit        in   flit_t  ACK source flit
//  ack_flit_valid  in   1       ACK source valid
//  ack_flit_ready  out  1       ACK source popped this cycle
//  retx_flit       in   flit_t  retransmit source flit
//  retx_flit_valid in   1       retransmit source valid
//  retx_flit_ready out  1       retransmit source popped
//  fwd_flit        in   flit_t  forwarded source flit
//  fwd_flit_valid  in   1       forwarded source valid
//  fwd_flit_ready  out  1       forwarded source popped
//  flit_out        out  flit_t  flit to interdevice TX
//  flit_out_valid  out  1       flit_out holds a flit
//  flit_out_ready  in   1       TX accepts flit_out this cycle
//  fwd_locked      out  1       status: mid forwarded packet
//  starve_pulse    out  1       1-cycle pulse when a forced (starvation) grant occurs
// BEHAVIOUR
//  - Reset: flit_out_valid=0, flit_out=0, fwd_locked=0, starve_pulse=0, counters=0, state IDLE.
//  - load = !flit_out_valid | flit_out_ready. Grant only when load=1; at most one *_ready high.
//    *_ready = grant & load (combinational from registered state + valids); no valid->ready loop.
//  - On grant: flit_out <= granted flit, flit_out_valid <= 1 next edge. Latency 1 cycle, full
//    throughput (one flit/cycle under continuous flit_out_ready). If load & no grant: valid <= 0.
//  - flit_out stable while flit_out_valid & !flit_out_ready.
//  - States: IDLE, LOCK_FWD.
//    IDLE priority: starved RETX > starved FWD > ACK > RETX > FWD.
//    IDLE -> LOCK_FWD when FWD granted with !types::is_tail_flit(fwd_flit).
//    LOCK_FWD: only FWD eligible (ACK/RETX wait); -> IDLE when FWD tail flit granted.
//    Single-flit (head+tail) FWD packet never enters LOCK_FWD.
//  - Starvation counter per RETX and FWD: +1 each cycle source valid & not granted (saturate at
//    STARVE_LIMIT); clear on grant or when valid=0. Starved = count==STARVE_LIMIT.
//    Counters also advance during LOCK_FWD; RETX forced grant takes effect on return to IDLE.
//  - starve_pulse=1 on the cycle after a grant chosen by the starved rule over a higher default.
//  - fwd_locked = (state==LOCK_FWD), registered.
//  - Mid-operation rst: output flit dropped, lock cleared, counters cleared; upstream queues keep
//    their contents (owned elsewhere).
//  - Source dropping valid while locked: arbiter stays LOCK_FWD, no grant, no timeout.
// STRUCTURE
//  - types package: flit_t, FLIT_W, function is_tail_flit(flit_t), enum tx_arb_state_t
//    {IDLE, LOCK_FWD}, enum tx_src_t {SRC_ACK, SRC_RETX, SRC_FWD, SRC_NONE}.
//  - One sub-module: starve_counter (CNT_W saturating counter, inc/clr, starved flag), x2.
//  - Grant logic is an always_comb block inside this module; output register + FSM in always_ff.
// TESTING
//  1 All three valid, flit_out_ready=1 always -> ACK flits drain first, each seen 1 cycle after
//    ack_flit_ready; RETX only after ACK valid falls.
//  2 ACK valid continuously, RETX valid, STARVE_LIMIT=4 -> RETX granted on 5th waiting cycle,
//    starve_pulse=1 exactly one cycle, counter back to 0.
//  3 FWD 3-flit packet (head,body,tail) with ACK valid from cycle 1 -> fwd_locked=1 after head,
//    ACK held until tail granted, then ACK granted next load.
//  4 flit_out_ready=0 for 5 cycles with valid output -> flit_out unchanged, all *_ready=0;
//    on ready=1 next grant follows with no bubble.
//  5 rst=1 mid FWD packet (after body) -> next cycle flit_out_valid=0, fwd_locked=0, counters 0;
//    ACK granted first after rst release.
//  6 Single-flit FWD (head+tail) alone -> fwd_locked stays 0, flit_out_valid pulses 1 cycle.

Source files
------------

// File: rtl/tx_flit_arbiter_pkg.sv
// tx_flit_arbiter_pkg: flit format, arbiter state and source encodings shared by the TX arbiter
package tx_flit_arbiter_pkg;
  localparam int FLIT_W = 34;
  typedef struct packed {
    logic                head;
    logic                tail;
    logic [FLIT_W-3:0]   data;
  } flit_t;
  typedef enum logic {IDLE, LOCK_FWD} tx_arb_state_t;
  typedef enum logic [1:0] {SRC_ACK, SRC_RETX, SRC_FWD, SRC_NONE} tx_src_t;
  function automatic logic is_tail_flit(flit_t f);
    return f.tail;
  endfunction
endpackage

// File: rtl/tx_flit_arbiter_starve_counter.sv
// starve_counter: saturating wait counter; starved once it has reached the limit
module starve_counter #(
  parameter int LIMIT = 16,
  parameter int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic starved
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && cnt != W'(LIMIT)) cnt <= cnt + 1'b1;
  assign starved = cnt == W'(LIMIT);
endmodule

// File: rtl/tx_flit_arbiter.sv
// tx_flit_arbiter: shares the inter-device TX port between ACK, retransmit and forwarded flit queues
module tx_flit_arbiter
  import tx_flit_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 16,
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic  nocclk,
  input  logic  rst,
  input  flit_t ack_flit,
  input  logic  ack_flit_valid,
  output logic  ack_flit_ready,
  input  flit_t retx_flit,
  input  logic  retx_flit_valid,
  output logic  retx_flit_ready,
  input  flit_t fwd_flit,
  input  logic  fwd_flit_valid,
  output logic  fwd_flit_ready,
  output flit_t flit_out,
  output logic  flit_out_valid,
  input  logic  flit_out_ready,
  output logic  fwd_locked,
  output logic  starve_pulse
);
  tx_arb_state_t state;
  tx_src_t dflt, pick, sel;
  flit_t granted;
  logic load, retx_st, fwd_st;
  assign load = !flit_out_valid || flit_out_ready;
  // Starved sources preempt the default order only in IDLE; a locked packet is never interrupted.
  always_comb begin
    dflt = ack_flit_valid ? SRC_ACK : retx_flit_valid ? SRC_RETX : fwd_flit_valid ? SRC_FWD : SRC_NONE;
    pick = state == LOCK_FWD ? (fwd_flit_valid ? SRC_FWD : SRC_NONE) :
           (retx_st && retx_flit_valid) ? SRC_RETX :
           (fwd_st && fwd_flit_valid) ? SRC_FWD : dflt;
    sel = load ? pick : SRC_NONE;
    granted = sel == SRC_ACK ? ack_flit : sel == SRC_RETX ? retx_flit : fwd_flit;
  end
  assign ack_flit_ready  = sel == SRC_ACK;
  assign retx_flit_ready = sel == SRC_RETX;
  assign fwd_flit_ready  = sel == SRC_FWD;
  assign fwd_locked      = state == LOCK_FWD;
  always_ff @(posedge nocclk)
    if (rst) begin
      flit_out       <= '0;
      flit_out_valid <= 1'b0;
      state          <= IDLE;
      starve_pulse   <= 1'b0;
    end else begin
      starve_pulse <= sel != SRC_NONE && state == IDLE && sel != dflt;
      if (load) flit_out_valid <= sel != SRC_NONE;
      if (sel != SRC_NONE) flit_out <= granted;
      if (sel == SRC_FWD) state <= is_tail_flit(fwd_flit) ? IDLE : LOCK_FWD;
    end
  starve_counter #(.LIMIT(STARVE_LIMIT), .W(CNT_W)) u_retx (
    .clk(nocclk), .rst(rst),
    .inc(retx_flit_valid && !retx_flit_ready),
    .clr(!retx_flit_valid || retx_flit_ready),
    .starved(retx_st)
  );
  starve_counter #(.LIMIT(STARVE_LIMIT), .W(CNT_W)) u_fwd (
    .clk(nocclk), .rst(rst),
    .inc(fwd_flit_valid && !fwd_flit_ready),
    .clr(!fwd_flit_valid || fwd_flit_ready),
    .starved(fwd_st)
  );
endmodule
